// File: rtl/axi_sram_arbiter.sv
// axi_sram_arbiter
//   Shares one AXI4-Lite SRAM slave between the instruction-fetch master (M0, read only)
//   and the data master (M1, read/write). One read and one write can be outstanding at the
//   slave at a time; the read and write paths run independently. Data reads are held
//   back while a data write is pending or being offered, so M1 read-after-write order holds.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   m0_ar*/m0_r*                  fetch master read address / read data channels
//   m1_ar*/m1_r*                  data master read address / read data channels
//   m1_aw*/m1_w*/m1_b*            data master write address / data / response channels
//   s_ar*/s_r*                    slave read channels
//   s_aw*/s_w*/s_b*               slave write channels
//
// Parameter
//   RR_MODE  1: round-robin read arbitration, 0: fixed priority with M1 always winning

module axi_sram_arbiter #(
  parameter bit RR_MODE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [31:0] m0_araddr,
  input  logic        m0_arvalid,
  output logic        m0_arready,
  output logic [31:0] m0_rdata,
  output logic        m0_rvalid,
  input  logic        m0_rready,

  input  logic [31:0] m1_araddr,
  input  logic        m1_arvalid,
  output logic        m1_arready,
  output logic [31:0] m1_rdata,
  output logic        m1_rvalid,
  input  logic        m1_rready,

  input  logic [31:0] m1_awaddr,
  input  logic        m1_awvalid,
  output logic        m1_awready,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  input  logic        m1_wvalid,
  output logic        m1_wready,
  output logic        m1_bvalid,
  input  logic        m1_bready,

  output logic [31:0] s_araddr,
  output logic        s_arvalid,
  input  logic        s_arready,
  input  logic [31:0] s_rdata,
  input  logic        s_rvalid,
  output logic        s_rready,

  output logic [31:0] s_awaddr,
  output logic        s_awvalid,
  input  logic        s_awready,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  output logic        s_wvalid,
  input  logic        s_wready,
  input  logic        s_bvalid,
  output logic        s_bready
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_RESP} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wr_state_e;

  // Master encoding for sel/last: 0 = M0, 1 = M1.
  rd_state_e   rd_state_q, rd_state_d;
  logic        sel_q, sel_d;
  logic        last_q, last_d;
  logic [31:0] araddr_q, araddr_d;

  wr_state_e   wr_state_q, wr_state_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;

  logic wr_block;
  logic m0_elig, m1_elig;
  logic win;
  logic aw_fin, w_fin;
  logic r_hs;

  // A write being offered this cycle also blocks M1 reads, since it is accepted now and
  // the read must not overtake it.
  assign wr_block = (wr_state_q != W_IDLE) || (m1_awvalid && m1_wvalid);

  // Gating with rst keeps every ready low while reset is held.
  assign m0_elig = m0_arvalid && !rst;
  assign m1_elig = m1_arvalid && !wr_block && !rst;

  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;
  assign s_araddr = araddr_q;
  assign s_awaddr = awaddr_q;
  assign s_wdata  = wdata_q;
  assign s_wstrb  = wstrb_q;

  // Read path
  always_comb begin
    rd_state_d = rd_state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    araddr_d   = araddr_q;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    win        = 1'b0;
    r_hs       = 1'b0;

    unique case (rd_state_q)
      R_IDLE: begin
        if (m0_elig || m1_elig) begin
          if (RR_MODE) begin
            win = (m0_elig && m1_elig) ? ~last_q : m1_elig;
          end else begin
            win = m1_elig;
          end
          if (win) begin
            m1_arready = 1'b1;
            araddr_d   = m1_araddr;
          end else begin
            m0_arready = 1'b1;
            araddr_d   = m0_araddr;
          end
          sel_d      = win;
          last_d     = win;
          rd_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        s_arvalid = 1'b1;
        if (s_arready) rd_state_d = R_RESP;
      end
      R_RESP: begin
        if (sel_q) begin
          m1_rvalid = s_rvalid;
          r_hs      = s_rvalid && m1_rready;
          s_rready  = m1_rready;
        end else begin
          m0_rvalid = s_rvalid;
          r_hs      = s_rvalid && m0_rready;
          s_rready  = m0_rready;
        end
        if (r_hs) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Write path
  always_comb begin
    wr_state_d = wr_state_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    s_awvalid  = 1'b0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    m1_bvalid  = 1'b0;
    aw_fin     = 1'b0;
    w_fin      = 1'b0;

    unique case (wr_state_q)
      W_IDLE: begin
        // Address and data are only ever taken together.
        if (m1_awvalid && m1_wvalid && !rst) begin
          m1_awready = 1'b1;
          m1_wready  = 1'b1;
          awaddr_d   = m1_awaddr;
          wdata_d    = m1_wdata;
          wstrb_d    = m1_wstrb;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_state_d = W_REQ;
        end
      end
      W_REQ: begin
        s_awvalid = !aw_done_q;
        s_wvalid  = !w_done_q;
        if (!aw_done_q && s_awready) aw_done_d = 1'b1;
        if (!w_done_q && s_wready) w_done_d = 1'b1;
        aw_fin = aw_done_q || s_awready;
        w_fin  = w_done_q || s_wready;
        if (aw_fin && w_fin) wr_state_d = W_RESP;
      end
      W_RESP: begin
        m1_bvalid = s_bvalid;
        s_bready  = m1_bready;
        if (s_bvalid && m1_bready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
      sel_q      <= 1'b0;
      last_q     <= 1'b1;  // M1 last, so M0 takes the first tie
      araddr_q   <= '0;
      wr_state_q <= W_IDLE;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      araddr_q   <= araddr_d;
      wr_state_q <= wr_state_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
    end
  end

endmodule

// File: doc/axi_sram_arbiter.md
# axi_sram_arbiter

Two-master AXI4-Lite arbiter that shares the unified SRAM slave between the instruction-fetch master (M0, read-only) and the data master (M1, read/write). It sits between the core's bus masters and the SRAM and keeps one read and one write outstanding at the slave. It arbitrates reads round-robin or with fixed data priority, and holds data reads behind in-flight data writes so read-after-write ordering is preserved.

## Interface
- RR_MODE, 1, 1 = round-robin read arbitration; 0 = fixed priority (M1 always wins)
- clk  in  1  clock
- rst  in  1  reset; synchronous and active-high, sampled on the rising edge of clk
- m0_araddr  in  32  fetch read address; m0_arvalid in 1; m0_arready out 1
- m0_rdata  out  32  fetch read data; m0_rvalid out 1; m0_rready in 1
- m1_araddr  in  32  data read address; m1_arvalid in 1; m1_arready out 1
- m1_rdata  out  32  data read data; m1_rvalid out 1; m1_rready in 1
- m1_awaddr  in  32; m1_awvalid in 1; m1_awready out 1  data write address
- m1_wdata  in  32; m1_wstrb in 4; m1_wvalid in 1; m1_wready out 1  data write payload
- m1_bvalid  out  1; m1_bready in 1  data write response
- s_araddr out 32; s_arvalid out 1; s_arready in 1; s_rdata in 32; s_rvalid in 1; s_rready out 1  slave read
- s_awaddr out 32; s_awvalid out 1; s_awready in 1; s_wdata out 32; s_wstrb out 4; s_wvalid out 1; s_wready in 1; s_bvalid in 1; s_bready out 1  slave write

## Operation
- Read FSM states: R_IDLE, R_ADDR and R_RESP. The grant register sel records M0 or M1. The last register records the last-granted master.
- R_IDLE: eligible requesters are m0_arvalid and m1_arvalid && !wr_block.
  - wr_block = (wr_state != W_IDLE) || (m1_awvalid && m1_wvalid).
  - Winner with RR_MODE=1: if both are eligible, the master not equal to last wins. Otherwise the sole eligible master wins.
  - Winner with RR_MODE=0: M1 wins whenever it is eligible.
  - On a grant: pulse the winner's arready for 1 cycle, latch its araddr into s_araddr, set sel and last, and go to R_ADDR.
- R_ADDR: s_arvalid=1 and s_araddr is held. On s_arready, go to R_RESP.
- R_RESP: m{sel}_rvalid = s_rvalid and s_rready = m{sel}_rready. The non-selected master's rvalid = 0. On s_rvalid && s_rready, go to R_IDLE.
- m0_rdata and m1_rdata are both driven by s_rdata; only the selected master's rvalid qualifies it.
- Write FSM states: W_IDLE, W_REQ and W_RESP. Flags aw_done and w_done track the slave handshakes.
- W_IDLE: on m1_awvalid && m1_wvalid, pulse m1_awready=m1_wready=1 in the same cycle. Latch awaddr, wdata and wstrb, clear both flags, and go to W_REQ.
  - A write is never accepted with only one of awvalid or wvalid asserted.
- W_REQ:
  - s_awvalid = !aw_done and s_wvalid = !w_done.
  - Set each flag on its slave handshake.
  - When both channels have completed (already done, or completing this cycle), go to W_RESP.
  - Both channels completing in the same cycle is legal.
- W_RESP: m1_bvalid = s_bvalid and s_bready = m1_bready. On handshake, go to W_IDLE.
- The read and write FSMs run independently. A write may proceed while an M0 or M1 read is in R_ADDR or R_RESP.

## Timing
- Reset values: all *_arready, *_awready, *_wready, *_rvalid, m1_bvalid, s_*valid, s_rready and s_bready are 0. s_araddr, s_awaddr, s_wdata and s_wstrb are 0. Read state is R_IDLE, write state is W_IDLE, and last = M1, so M0 wins the first tie.
- Reset asserted mid-transaction abandons it with no response to the master. The slave must be reset in the same cycle.
- Read latency: master AR handshake at cycle T; s_arvalid at T+1. With a slave that accepts immediately and has 1-cycle data, m_rvalid is at T+2.
  - Read throughput is at best one read per 3 cycles, because R_RESP→R_IDLE costs one cycle before the next grant.
- Write latency: master handshake at T; s_awvalid and s_wvalid at T+1; m1_bvalid no earlier than T+2.
- The arready, awready and wready pulses are single-cycle and are registered in FSM terms (asserted only in the IDLE states). In R_IDLE they depend combinationally on the valids.
- A grant is decided only in R_IDLE. Requests arriving in other states wait, with valid held by the master per AXI rules.
- Ordering guarantee: an M1 read issued after an M1 write is never presented to the slave before that write's B handshake completes.

## Test plan
- Single M0 read of 0x0000_0010, SRAM returns 0x0000_0013. Required: m0_arready at T, s_arvalid at T+1, m0_rvalid with rdata 0x0000_0013 at T+2, m1_rvalid stays 0.
- RR_MODE=1, M0 and M1 both hold arvalid continuously for 4 reads. Required: grants alternate M0, M1, M0, M1, with M0 first after reset. With RR_MODE=0 the same stimulus grants M1 every time and M0 starves.
- M1 writes 0xDEADBEEF to 0x100 with wstrb=0xF while M1 asserts a read of 0x100 in the same cycle. Required: the read is not granted until the cycle after m1_bvalid && m1_bready, then returns 0xDEADBEEF. An M0 read in the same window is granted immediately.
- Slave delays s_awready by 3 cycles relative to s_wready. Required: s_wvalid drops after its handshake, s_awvalid holds until its handshake, and exactly one write reaches the slave.
- Masters hold rready=0 and bready=0 for 5 cycles. Required: s_rready and s_bready stay 0, states hold, data is unchanged, and handshakes complete on the cycle the ready is raised.
- rst asserted while in R_RESP and W_REQ. Required: all outputs are at reset values the following cycle, and a fresh M0 read then completes normally.
